// File: rtl/mac_array_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_array_if
// Description : Sample/result bundle between the sample source, the mac_array
//               and the downstream filter/decision logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_array_if #(
    parameter int IN1_WIDTH = 8,
    parameter int IN2_WIDTH = 8,
    parameter int OUT_WIDTH = 24,
    parameter int N_LANES   = 4
);
    logic                           LOAD;
    logic [N_LANES*IN1_WIDTH-1:0]   A;
    logic [N_LANES*IN2_WIDTH-1:0]   B;
    logic [N_LANES*OUT_WIDTH-1:0]   MAC_OUT;
    logic                           OUT_VALID;
    logic                           BUSY;
    logic [N_LANES-1:0]             OVF;

    modport master (
        output LOAD, A, B,
        input  MAC_OUT, OUT_VALID, BUSY, OVF
    );

    modport slave (
        input  LOAD, A, B,
        output MAC_OUT, OUT_VALID, BUSY, OVF
    );
endinterface
`default_nettype wire

// File: rtl/mac_array.sv
`default_nettype none
// ============================================================================
// Module      : mac_array
// Description : N-lane pipelined signed multiply-accumulator producing one
//               VEC_LEN-sample dot product per lane. Define MAC_ARRAY_SAT_EN
//               to saturate instead of wrap on accumulator overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_array #(
    parameter int IN1_WIDTH = 8,
    parameter int IN2_WIDTH = 8,
    parameter int OUT_WIDTH = 24,
    parameter int N_LANES   = 4,
    parameter int VEC_LEN   = 8
) (
    input  wire logic   SYS_CLK,
    input  wire logic   SCLR,
    mac_array_if.slave  bus
);

    localparam int PROD_WIDTH = IN1_WIDTH + IN2_WIDTH;
    localparam int CNT_WIDTH  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int MSB        = OUT_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(VEC_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // Product stage
    logic [N_LANES-1:0][PROD_WIDTH-1:0] p_q, p_d;
    logic                               p_valid_q, p_valid_d;
    logic [N_LANES-1:0][PROD_WIDTH-1:0] prod_w;

    // Accumulate stage
    logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
    logic [N_LANES-1:0][OUT_WIDTH-1:0]  acc_q, acc_d;
    logic [N_LANES-1:0]                 ovf_run_q, ovf_run_d;
    logic [N_LANES-1:0][OUT_WIDTH-1:0]  sum_w;
    logic [N_LANES-1:0]                 add_ovf_w;

    // Result registers
    logic [N_LANES-1:0][OUT_WIDTH-1:0]  mac_out_q, mac_out_d;
    logic [N_LANES-1:0]                 ovf_q, ovf_d;
    logic                               out_valid_q, out_valid_d;

    logic [0:0]                         state_q, state_d;
    logic                               busy_w;
    logic                               first_w;

    assign first_w = (cnt_q == '0);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic signed [IN1_WIDTH-1:0]  a_s;
        logic signed [IN2_WIDTH-1:0]  b_s;
        logic signed [PROD_WIDTH-1:0] prod_s;
        logic signed [OUT_WIDTH-1:0]  base_s;
        logic signed [OUT_WIDTH-1:0]  addend_s;
        logic signed [OUT_WIDTH-1:0]  raw_s;

        assign a_s       = bus.A[i*IN1_WIDTH +: IN1_WIDTH];
        assign b_s       = bus.B[i*IN2_WIDTH +: IN2_WIDTH];
        assign prod_s    = a_s * b_s;
        assign prod_w[i] = prod_s;

        // A new vector starts from zero instead of the stale accumulator.
        assign base_s   = first_w ? '0 : $signed(acc_q[i]);
        assign addend_s = OUT_WIDTH'($signed(p_q[i]));
        assign raw_s    = base_s + addend_s;

        assign add_ovf_w[i] = (base_s[MSB] == addend_s[MSB]) && (raw_s[MSB] != base_s[MSB]);

`ifdef MAC_ARRAY_SAT_EN
        localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        // Overflow direction follows the common operand sign.
        assign sum_w[i] = !add_ovf_w[i] ? raw_s : (base_s[MSB] ? SAT_MIN : SAT_MAX);
`else
        assign sum_w[i] = raw_s;
`endif
    end

    always_comb begin
        p_valid_d   = bus.LOAD;
        p_d         = bus.LOAD ? prod_w : p_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_run_d   = ovf_run_q;
        mac_out_d   = mac_out_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (p_valid_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                out_valid_d = 1'b1;
                mac_out_d   = sum_w;
                for (int i = 0; i < N_LANES; i++) begin
                    ovf_d[i] = (!first_w && ovf_run_q[i]) || add_ovf_w[i];
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
                acc_d = sum_w;
                for (int i = 0; i < N_LANES; i++) begin
                    ovf_run_d[i] = (!first_w && ovf_run_q[i]) || add_ovf_w[i];
                end
            end
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SCLR) begin
            p_q         <= '0;
            p_valid_q   <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_run_q   <= '0;
            mac_out_q   <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            p_valid_q   <= p_valid_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_run_q   <= ovf_run_d;
            mac_out_q   <= mac_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SCLR) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (p_valid_d) state_d = ST_ACCUM;
            ST_ACCUM: if ((cnt_d == '0) && !p_valid_d) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_w = 1'b0;
        case (state_q)
            ST_ACCUM: busy_w = 1'b1;
            default:  busy_w = 1'b0;
        endcase
    end

    assign bus.MAC_OUT   = mac_out_q;
    assign bus.OVF       = ovf_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.BUSY      = busy_w;

endmodule
`default_nettype wire

// File: tb/tb_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_array
// Description : Directed self-checking bench for mac_array; a 24-bit and a
//               16-bit instance share stimulus and are checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_array;

    localparam int NL = 4;
    localparam int VL = 8;
    localparam int WA = 24;
    localparam int WB = 16;

    logic        clk = 1'b0;
    logic        sclr;
    logic        load;
    logic [31:0] a;
    logic [31:0] b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit check_en = 1'b0;

    mac_array_if #(.IN1_WIDTH(8), .IN2_WIDTH(8), .OUT_WIDTH(WA), .N_LANES(NL)) if_a ();
    mac_array_if #(.IN1_WIDTH(8), .IN2_WIDTH(8), .OUT_WIDTH(WB), .N_LANES(NL)) if_b ();

    assign if_a.LOAD = load;
    assign if_a.A    = a;
    assign if_a.B    = b;
    assign if_b.LOAD = load;
    assign if_b.A    = a;
    assign if_b.B    = b;

    mac_array #(.IN1_WIDTH(8), .IN2_WIDTH(8), .OUT_WIDTH(WA), .N_LANES(NL), .VEC_LEN(VL)) dut_a (
        .SYS_CLK (clk),
        .SCLR    (sclr),
        .bus     (if_a)
    );

    mac_array #(.IN1_WIDTH(8), .IN2_WIDTH(8), .OUT_WIDTH(WB), .N_LANES(NL), .VEC_LEN(VL)) dut_b (
        .SYS_CLK (clk),
        .SCLR    (sclr),
        .bus     (if_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    int     prods [NL][VL];
    int     pp    [NL];
    bit     pend  = 1'b0;
    int     accn  = 0;
    longint exp_out [2][NL];
    bit     exp_ovf [2][NL];
    bit     exp_valid = 1'b0;
    bit     exp_busy  = 1'b0;

    // Dot product of one lane in w-bit signed arithmetic, flagging overflow.
    function automatic void reduce(input int w, input int l, output longint r, output bit o);
        longint s, t, mx, mn, m;
        m  = longint'(1) << w;
        mx = (m >>> 1) - 1;
        mn = -(m >>> 1);
        s  = 0;
        o  = 1'b0;
        for (int k = 0; k < VL; k++) begin
            t = s + longint'(prods[l][k]);
            if (t > mx || t < mn) begin
                o = 1'b1;
`ifdef MAC_ARRAY_SAT_EN
                s = (t > mx) ? mx : mn;
`else
                s = t & (m - 1);
                if (s > mx) s = s - m;
`endif
            end else begin
                s = t;
            end
        end
        r = s;
    endfunction

    always @(posedge clk) begin
        if (sclr) begin
            pend = 1'b0;
            accn = 0;
            exp_valid = 1'b0;
            for (int w = 0; w < 2; w++)
                for (int l = 0; l < NL; l++) begin
                    exp_out[w][l] = 0;
                    exp_ovf[w][l] = 1'b0;
                end
        end else begin
            exp_valid = 1'b0;
            if (pend) begin
                for (int l = 0; l < NL; l++) prods[l][accn] = pp[l];
                accn++;
                if (accn == VL) begin
                    for (int l = 0; l < NL; l++) begin
                        reduce(WA, l, exp_out[0][l], exp_ovf[0][l]);
                        reduce(WB, l, exp_out[1][l], exp_ovf[1][l]);
                    end
                    exp_valid = 1'b1;
                    accn = 0;
                end
            end
            pend = load;
            if (load)
                for (int l = 0; l < NL; l++)
                    pp[l] = int'($signed(a[l*8 +: 8])) * int'($signed(b[l*8 +: 8]));
        end
        exp_busy = pend || (accn != 0);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int     n_pulses = 0;
    int     last_cyc = 0;
    int     prev_cyc = 0;
    longint last_a [NL];
    longint last_b [NL];
    logic [NL-1:0] last_ovf_a;
    logic [NL-1:0] last_ovf_b;

    always @(negedge clk) begin
        logic signed [WA-1:0] va;
        logic signed [WB-1:0] vb;
        if (check_en) begin
            check("valid_a", longint'(if_a.OUT_VALID), longint'(exp_valid));
            check("valid_b", longint'(if_b.OUT_VALID), longint'(exp_valid));
            check("busy_a",  longint'(if_a.BUSY),      longint'(exp_busy));
            check("busy_b",  longint'(if_b.BUSY),      longint'(exp_busy));
            for (int l = 0; l < NL; l++) begin
                va = if_a.MAC_OUT[l*WA +: WA];
                vb = if_b.MAC_OUT[l*WB +: WB];
                check($sformatf("out_a[%0d]", l), longint'(va), exp_out[0][l]);
                check($sformatf("out_b[%0d]", l), longint'(vb), exp_out[1][l]);
                check($sformatf("ovf_a[%0d]", l), longint'(if_a.OVF[l]), longint'(exp_ovf[0][l]));
                check($sformatf("ovf_b[%0d]", l), longint'(if_b.OVF[l]), longint'(exp_ovf[1][l]));
            end
            if (if_a.OUT_VALID) begin
                n_pulses++;
                prev_cyc = last_cyc;
                last_cyc = cyc;
                for (int l = 0; l < NL; l++) begin
                    va = if_a.MAC_OUT[l*WA +: WA];
                    vb = if_b.MAC_OUT[l*WB +: WB];
                    last_a[l] = va;
                    last_b[l] = vb;
                end
                last_ovf_a = if_a.OVF;
                last_ovf_b = if_b.OVF;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit s, input bit l, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        sclr = s;
        load = l;
        a    = av;
        b    = bv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rep(input logic [7:0] x);
        return {4{x}};
    endfunction

    localparam logic [31:0] A_RAMP = {8'd4, 8'd3, 8'd2, 8'd1};

    int p0;
    int drive_cyc;

    initial begin
        sclr = 1'b1;
        load = 1'b1;
        a    = $urandom;
        b    = $urandom;
        @(posedge clk);
        check_en = 1'b1;
        drive(1'b1, 1'b1, $urandom, $urandom);
        @(posedge clk);
        #1;
        check("rst_out_a", longint'(|if_a.MAC_OUT), 0);
        check("rst_ovf_a", longint'(|if_a.OVF), 0);
        check("rst_valid", longint'(if_a.OUT_VALID), 0);
        check("rst_busy",  longint'(if_a.BUSY), 0);

        // Two back-to-back vectors
        p0 = n_pulses;
        for (int v = 0; v < 2; v++)
            for (int k = 1; k <= VL; k++) drive(1'b0, 1'b1, A_RAMP, rep(8'(k)));
        drive_cyc = cyc;
        idle(5);
        check("b2b_pulses", n_pulses - p0, 2);
        check("b2b_spacing", last_cyc - prev_cyc, VL);
        check("b2b_latency", last_cyc, drive_cyc + 2);
        for (int l = 0; l < NL; l++) check($sformatf("b2b_lane%0d", l), last_a[l], 36 * (l + 1));

        // Gapped LOAD
        p0 = n_pulses;
        for (int k = 1; k <= VL; k++) begin
            drive(1'b0, 1'b1, A_RAMP, rep(8'(k)));
            drive(1'b0, 1'b0, 32'h0, 32'h0);
        end
        idle(4);
        check("gap_pulses", n_pulses - p0, 1);
        for (int l = 0; l < NL; l++) check($sformatf("gap_lane%0d", l), last_a[l], 36 * (l + 1));

        // Overflow vector then a small negative vector
        for (int k = 0; k < VL; k++) drive(1'b0, 1'b1, rep(8'd127), rep(8'd127));
        idle(3);
`ifdef MAC_ARRAY_SAT_EN
        check("ovf16_lane0", last_b[0], 32767);
`else
        check("ovf16_lane0", last_b[0], -2040);
`endif
        check("ovf16_flags", longint'(last_ovf_b), 15);
        check("ovf24_lane3", last_a[3], 129032);
        check("ovf24_flags", longint'(last_ovf_a), 0);
        for (int k = 0; k < VL; k++) drive(1'b0, 1'b1, rep(8'hFF), rep(8'd1));
        idle(3);
        check("neg16_lane2", last_b[2], -8);
        check("neg16_flags", longint'(last_ovf_b), 0);

        // Mixed signs per lane
        for (int k = 0; k < VL; k++)
            drive(1'b0, 1'b1, {8'd3, 8'hFB, 8'h80, 8'd127}, {8'h80, 8'd7, 8'h80, 8'hFF});
        idle(3);
        check("mix24_lane1", last_a[1], 131072);
        check("mix16_lane1", longint'(last_ovf_b[1]), 1);
        check("mix24_lane2", last_a[2], -280);

        // Mid-vector SCLR
        p0 = n_pulses;
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, rep(8'd1), rep(8'd1));
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < VL; k++) drive(1'b0, 1'b1, rep(8'd2), rep(8'd3));
        idle(3);
        check("midrst_pulses", n_pulses - p0, 1);
        check("midrst_lane0", last_a[0], 48);

        // SCLR and LOAD on the same edge
        p0 = n_pulses;
        drive(1'b1, 1'b1, rep(8'd1), rep(8'd1));
        for (int k = 0; k < VL; k++) drive(1'b0, 1'b1, rep(8'd1), rep(8'd1));
        idle(3);
        check("collide_pulses", n_pulses - p0, 1);
        check("collide_lane3", last_a[3], 8);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_array.md
# mac_array

Parametrised, pipelined multi-lane multiply-accumulator. It is the successor to the single-lane MAC and extends it with N parallel signed lanes and a fixed dot-product length. Each lane accumulates VEC_LEN valid samples, then presents the result with a one-cycle valid pulse and restarts automatically with no dead cycle. It sits in the datapath between the sample source and the downstream filter/decision logic.

## Interface
- IN1_WIDTH, 8: width of each signed A lane element
- IN2_WIDTH, 8: width of each signed B lane element
- OUT_WIDTH, 24: accumulator/result width per lane; must be >= IN1_WIDTH+IN2_WIDTH
- N_LANES, 4: number of parallel lanes (>= 1)
- VEC_LEN, 8: samples per dot product (>= 1)

- SYS_CLK  in  1  system clock, rising edge
- SCLR  in  1  reset, synchronous, active-high
- LOAD  in  1  sample valid; A/B captured on an edge where LOAD=1 and SCLR=0
- A  in  N_LANES*IN1_WIDTH  lane i at [i*IN1_WIDTH +: IN1_WIDTH], two's complement
- B  in  N_LANES*IN2_WIDTH  lane i at [i*IN2_WIDTH +: IN2_WIDTH], two's complement
- MAC_OUT  out  N_LANES*OUT_WIDTH  lane i result at [i*OUT_WIDTH +: OUT_WIDTH], signed; held until next result
- OUT_VALID  out  1  one-cycle pulse, MAC_OUT updated
- BUSY  out  1  partial vector or product in flight
- OVF  out  N_LANES  per-lane overflow flag for the vector currently on MAC_OUT

## Operation
- Stage P: on an edge with LOAD=1, p_i <= A_i*B_i (signed, IN1_WIDTH+IN2_WIDTH bits). p_valid <= LOAD.
- Stage ACC: on an edge with p_valid=1, the lane computes sum_i = base_i + sext(p_i). base_i is 0 when cnt==0; otherwise it is acc_i.
- Counter cnt runs 0..VEC_LEN-1 and advances only when p_valid=1.
  - If cnt < VEC_LEN-1: acc_i <= sum_i and cnt increments.
  - If cnt == VEC_LEN-1: MAC_OUT_i <= sum_i, OVF_i <= the lane's overflow flag ORed with this addition's overflow, OUT_VALID <= 1, cnt <= 0.
- The lane overflow flag is reset at cnt==0 and accumulates over the vector.
- States:
  - IDLE (cnt==0, p_valid=0)
  - ACCUM (cnt>0 or p_valid=1)
  - ACCUM -> IDLE when the final sample is accumulated and no new product is pending.
- BUSY = (cnt!=0) | p_valid.
- LOAD gaps are allowed: all state holds while LOAD=0. There is no timeout.
- Back-to-back vectors: the first sample of vector n+1 may be in stage P while the last sample of vector n is in stage ACC. No sample is lost.
- Overflow is signed overflow of the OUT_WIDTH addition. This can only occur when the accumulated sum exceeds the range.
- VEC_LEN=1: every sample produces a result; OUT_VALID tracks LOAD delayed by 2 edges.
- SCLR=1: on that edge all registers clear (cnt, acc, p_valid, MAC_OUT, OVF, OUT_VALID, BUSY -> 0). Any in-flight product or partial vector is discarded. LOAD on the same edge is ignored.
- Reset values: MAC_OUT=0, OUT_VALID=0, BUSY=0, OVF=0.

## Timing
- Sample captured at edge k, product at edge k, accumulated at edge k+1.
- For the final sample of a vector, MAC_OUT/OVF update and OUT_VALID is high in the cycle after edge k+1, for exactly one cycle.
- Throughput: one sample per cycle per lane. With continuous LOAD, OUT_VALID pulses every VEC_LEN cycles.
- No combinational path from inputs to outputs.

## Configuration
- MAC_ARRAY_SAT_EN defined:
  - Each accumulation clamps to +(2^(OUT_WIDTH-1))-1 or -2^(OUT_WIDTH-1) on overflow.
  - Subsequent samples accumulate from the clamped value.
  - OVF is set.
- MAC_ARRAY_SAT_EN undefined:
  - Two's-complement wrap modulo 2^OUT_WIDTH.
  - OVF is still set on any overflow within the vector.

## Test plan
- Reset: hold SCLR 2 cycles with LOAD=1 and random A/B -> MAC_OUT=0, OVF=0, OUT_VALID=0, BUSY=0 throughout.
- Continuous vector (defaults): A lanes {1,2,3,4} constant, B all lanes = 1..8 over 8 LOAD cycles -> one OUT_VALID pulse 2 edges after the last capture, MAC_OUT {36,72,108,144}. Repeat back-to-back -> identical results, pulses exactly 8 cycles apart.
- Gapped LOAD: same data with LOAD alternating 1/0 -> same results {36,72,108,144}, BUSY high from the first capture until the cycle after the final accumulation.
- Signed and overflow (OUT_WIDTH=16): A=127, B=127 on all lanes for 8 samples.
  - Without the macro -> MAC_OUT=-2040 (129032 wrapped), OVF=all ones.
  - With MAC_ARRAY_SAT_EN -> MAC_OUT=32767, OVF=all ones.
  - Next vector with A=-1, B=1 -> MAC_OUT=-8, OVF=0.
- Mid-vector SCLR: 5 samples, then a 1-cycle SCLR, then 8 samples of A=2, B=3 -> no OUT_VALID for the partial vector; a single result of 48 per lane.
- Simultaneous SCLR and LOAD: assert both on one edge, then 8 normal samples of A=1, B=1 -> the colliding sample is dropped; result is 8, not 9.
